// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// The optional checksum stage is enabled by defining UART_LOADER_CHECKSUM_EN.
package uart_loader_pkg;

    // Serial frame shape: 8 data bits, no parity, 1 stop bit.
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;

    // Datapath widths.
    localparam int WORD_W     = 32;
    localparam int BYTE_IDX_W = 2;
    localparam int WORD_CNT_W = 15;

    // Loader FSM states. S_CSUM is only reachable when the checksum stage is built in.
    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_t;

    // Receiver frame sampler states.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int calc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clock cycles per oversample tick, rounded down.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: rx synchronizer, free-running oversample tick divider
// and a mid-bit frame sampler. byte_valid / frame_err are one-cycle pulses issued
// the cycle after the stop-bit sample.
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int DIV     = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int DIV_W   = calc_width(DIV);
    localparam int OS_W    = calc_width(OVERSAMPLE);
    localparam int OS_HALF = OVERSAMPLE / 2 - 1;
    localparam int OS_LAST = OVERSAMPLE - 1;

    logic [1:0]       r_rx_sync;
    logic             r_rx_prev;
    logic [DIV_W-1:0] r_div_cnt;
    logic [OS_W-1:0]  r_os_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic             r_frame_err;
    rx_state_t        r_state;

    rx_state_t        w_state_next;
    logic             w_rx;
    logic             w_tick;
    logic             w_os_clr;
    logic             w_shift;
    logic             w_byte_valid;
    logic             w_frame_err;

    assign w_rx   = r_rx_sync[1];
    assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

    // Two-flop synchronizer plus one history flop for falling-edge detection; idles high.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
        if (rst) begin
            r_rx_sync <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_sync <= {r_rx_sync[0], rx};
            r_rx_prev <= w_rx;
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge clk) begin
        if (rst) r_div_cnt <= '0;
        else     r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
    end

    // Frame sampler state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= RX_IDLE;
        else     r_state <= w_state_next;
    end

    // Frame sampler next-state and per-cycle control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_state_next = r_state;
        w_os_clr     = 1'b0;
        w_shift      = 1'b0;
        w_byte_valid = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (r_rx_prev && !w_rx) begin
                    w_state_next = RX_START;
                    w_os_clr     = 1'b1;
                end
            end
            RX_START: begin
                // Start bit re-checked mid-bit; a high line here means a glitch.
                if (w_tick && r_os_cnt == OS_W'(OS_HALF)) begin
                    w_os_clr     = 1'b1;
                    w_state_next = w_rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_tick && r_os_cnt == OS_W'(OS_LAST)) begin
                    w_os_clr = 1'b1;
                    w_shift  = 1'b1;
                    if (r_bit_cnt == 3'(DATA_BITS - 1)) w_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_tick && r_os_cnt == OS_W'(OS_LAST)) begin
                    w_state_next = RX_IDLE;
                    w_byte_valid = w_rx;
                    w_frame_err  = !w_rx;
                end
            end
            default: w_state_next = RX_IDLE;
        endcase
    end

    // Oversample/bit counters, LSB-first shift register and registered result strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_os_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (w_os_clr)    r_os_cnt <= '0;
            else if (w_tick) r_os_cnt <= r_os_cnt + 1'b1;

            if (r_state == RX_IDLE) r_bit_cnt <= '0;
            else if (w_shift)       r_bit_cnt <= r_bit_cnt + 1'b1;

            if (w_shift) r_shift <= {w_rx, r_shift[7:1]};

            r_byte_valid <= w_byte_valid;
            r_frame_err  <= w_frame_err;
        end
    end

    assign byte_valid = r_byte_valid;
    assign byte_data  = r_shift;
    assign frame_err  = r_frame_err;

endmodule

// File: rtl/uart_loader.sv
// Serial boot loader top: header word N, then N little-endian payload words are
// presented on uart_data/uart_addr with a one-cycle uart_wr, then uart_done
// releases the core. Define UART_LOADER_CHECKSUM_EN to require a trailing
// mod-2^32 sum word after the payload.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int          CLK_FREQ   = 50000000,
    parameter int          BAUD       = 115200,
    parameter int          OVERSAMPLE = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          MAX_WORDS  = 16384
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [WORD_W-1:0]     uart_data,
    output logic [WORD_W-1:0]     uart_addr,
    output logic                  uart_wr,
    output logic                  uart_done,
    output logic                  busy,
    output logic                  load_err,
    output logic [WORD_CNT_W-1:0] word_cnt
);

    logic                  w_rx_valid;
    logic [7:0]            w_rx_data;
    logic                  w_rx_err;

    loader_state_t         r_state;
    logic [BYTE_IDX_W-1:0] r_byte_idx;
    logic [23:0]           r_asm;
    logic [WORD_W-1:0]     r_count;
    logic [WORD_W-1:0]     r_data;
    logic [WORD_W-1:0]     r_addr;
    logic                  r_wr;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_err;
    logic [WORD_CNT_W-1:0] r_word_cnt;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]     r_sum;
`endif

    loader_state_t         w_state_next;
    logic                  w_accepting;
    logic                  w_byte_ok;
    logic                  w_frm_err;
    logic                  w_word_done;
    logic [WORD_W-1:0]     w_word;
    logic [WORD_W-1:0]     w_addr;
    logic                  w_last;
    logic                  w_wr;
    logic                  w_set_err;

    uart_rx_byte #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (w_rx_valid),
        .byte_data  (w_rx_data),
        .frame_err  (w_rx_err)
    );

    // Bytes are only consumed while a load is still open; DONE and ERR ignore the line.
    assign w_accepting = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_byte_ok   = w_accepting && w_rx_valid;
    assign w_frm_err   = w_accepting && w_rx_err;
    assign w_word_done = w_byte_ok && (r_byte_idx == 2'd3);
    assign w_word      = {w_rx_data, r_asm};
    assign w_addr      = BASE_ADDR + {15'b0, r_word_cnt, 2'b00};
    assign w_last      = ({17'b0, r_word_cnt} + 32'd1) == r_count;

    // Loader FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_HDR;
        else     r_state <= w_state_next;
    end

    // Loader FSM next-state, write strobe and error strobe.
    always_comb begin
        w_state_next = r_state;
        w_wr         = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            S_HDR: begin
                if (w_frm_err) begin
                    w_state_next = S_ERR;
                    w_set_err    = 1'b1;
                end else if (w_word_done) begin
                    if (w_word == '0) begin
                        w_state_next = S_DONE;
                    end else if (w_word > 32'(MAX_WORDS)) begin
                        w_state_next = S_ERR;
                        w_set_err    = 1'b1;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_frm_err) begin
                    w_state_next = S_ERR;
                    w_set_err    = 1'b1;
                end else if (w_word_done) begin
                    w_wr = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                    if (w_last) w_state_next = S_CSUM;
`else
                    if (w_last) w_state_next = S_DONE;
`endif
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_frm_err) begin
                    w_state_next = S_ERR;
                    w_set_err    = 1'b1;
                end else if (w_word_done) begin
                    if (w_word == r_sum) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_ERR;
                        w_set_err    = 1'b1;
                    end
                end
            end
`endif
            S_DONE:  w_state_next = S_DONE;
            S_ERR:   w_state_next = S_ERR;
            default: w_state_next = S_ERR;
        endcase
    end

    // Word assembly, header capture, output registers and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_count    <= '0;
            r_data     <= '0;
            r_addr     <= '0;
            r_wr       <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_word_cnt <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            if (w_byte_ok) begin
                r_byte_idx <= r_byte_idx + 1'b1;
                case (r_byte_idx)
                    2'd0:    r_asm[7:0]   <= w_rx_data;
                    2'd1:    r_asm[15:8]  <= w_rx_data;
                    2'd2:    r_asm[23:16] <= w_rx_data;
                    default: r_asm        <= r_asm;
                endcase
            end

            if (r_state == S_HDR && w_word_done) r_count <= w_word;

            if (w_wr) begin
                r_data     <= w_word;
                r_addr     <= w_addr;
                r_word_cnt <= r_word_cnt + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                r_sum      <= r_sum + w_word;
`endif
            end

            r_wr   <= w_wr;
            r_done <= (r_state == S_DONE);
            r_busy <= (w_state_next == S_DATA) || (w_state_next == S_CSUM);
            if (w_set_err) r_err <= 1'b1;
        end
    end

    assign uart_data = r_data;
    assign uart_addr = r_addr;
    assign uart_wr   = r_wr;
    assign uart_done = r_done;
    assign busy      = r_busy;
    assign load_err  = r_err;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_uart_loader.sv
// Directed self-checking bench for uart_loader. The baud divider is shrunk to 2
// clocks per tick (32 clocks per bit) to keep the run short.
module tb_uart_loader;

    localparam int CLK_FREQ   = 3686400;
    localparam int BAUD       = 115200;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = (CLK_FREQ / (BAUD * OVERSAMPLE)) * OVERSAMPLE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [31:0] uart_data;
    logic [31:0] uart_addr;
    logic        uart_wr;
    logic        uart_done;
    logic        busy;
    logic        load_err;
    logic [14:0] word_cnt;

    int checks   = 0;
    int failures = 0;

    // Monitor state (written only by the monitor process).
    int          cyc           = 0;
    logic        done_prev     = 1'b0;
    int          done_rise_cyc = -1;
    logic [31:0] wr_data_q[$];
    logic [31:0] wr_addr_q[$];
    int          wr_cyc_q[$];

    int base;

    uart_loader #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE),
        .BASE_ADDR  (32'h0),
        .MAX_WORDS  (16384)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .uart_data  (uart_data),
        .uart_addr  (uart_addr),
        .uart_wr    (uart_wr),
        .uart_done  (uart_done),
        .busy       (busy),
        .load_err   (load_err),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    // Sample outputs on the falling edge: log every write pulse and the latest done rise.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (uart_wr) begin
            wr_data_q.push_back(uart_data);
            wr_addr_q.push_back(uart_addr);
            wr_cyc_q.push_back(cyc);
        end
        if (uart_done && !done_prev) done_rise_cyc = cyc;
        done_prev = uart_done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop_ok;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    initial begin
        // Reset state.
        do_reset();
        check("rst_data", uart_data, 32'h0);
        check("rst_addr", uart_addr, 32'h0);
        check("rst_flags", {27'b0, uart_wr, uart_done, busy, load_err}, 32'h0);
        check("rst_cnt", {17'b0, word_cnt}, 32'h0);

        // Short low glitch on rx must not be taken as a start bit.
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("glitch_busy", {30'b0, busy, load_err}, 32'h0);
        check("glitch_cnt", {17'b0, word_cnt}, 32'h0);

        // Three-word load.
        base = wr_data_q.size();
        send_word(32'd3);
        check("hdr3_busy", {31'b0, busy}, 32'h1);
        send_word(32'h00000013);
        send_word(32'hDEADBEEF);
        send_word(32'h12345678);
        repeat (4) @(negedge clk);
        check("l3_nwr", wr_data_q.size() - base, 3);
        if (wr_data_q.size() - base == 3) begin
            check("l3_d0", wr_data_q[base],     32'h00000013);
            check("l3_a0", wr_addr_q[base],     32'h0);
            check("l3_d1", wr_data_q[base + 1], 32'hDEADBEEF);
            check("l3_a1", wr_addr_q[base + 1], 32'h4);
            check("l3_d2", wr_data_q[base + 2], 32'h12345678);
            check("l3_a2", wr_addr_q[base + 2], 32'h8);
            check("l3_done_lat", done_rise_cyc, wr_cyc_q[base + 2] + 1);
        end
        check("l3_done", {30'b0, uart_done, busy}, 32'h2);
        check("l3_err", {31'b0, load_err}, 32'h0);
        check("l3_cnt", {17'b0, word_cnt}, 32'd3);
        // Traffic after completion is ignored.
        send_word(32'hFFFFFFFF);
        repeat (4) @(negedge clk);
        check("l3_post_nwr", wr_data_q.size() - base, 3);
        check("l3_post_data", uart_data, 32'h12345678);
        check("l3_post_cnt", {17'b0, word_cnt}, 32'd3);

        // Zero-length load.
        do_reset();
        base = wr_data_q.size();
        send_word(32'd0);
        repeat (4) @(negedge clk);
        check("h0_done", {31'b0, uart_done}, 32'h1);
        check("h0_nwr", wr_data_q.size() - base, 0);
        send_word(32'h00000002);
        send_word(32'hA5A5A5A5);
        repeat (4) @(negedge clk);
        check("h0_post_nwr", wr_data_q.size() - base, 0);
        check("h0_post_out", uart_data | uart_addr, 32'h0);
        check("h0_post_flags", {29'b0, uart_done, busy, load_err}, 32'h4);

        // Framing error inside payload word 1.
        do_reset();
        base = wr_data_q.size();
        send_word(32'd2);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        repeat (4) @(negedge clk);
        check("ferr_flags", {29'b0, uart_done, busy, load_err}, 32'h1);
        send_byte(8'h33, 1'b1);
        send_word(32'h01020304);
        send_word(32'h05060708);
        repeat (4) @(negedge clk);
        check("ferr_nwr", wr_data_q.size() - base, 0);
        check("ferr_post", {29'b0, uart_done, busy, load_err}, 32'h1);
        check("ferr_cnt", {17'b0, word_cnt}, 32'h0);

        // Oversized header is rejected.
        do_reset();
        send_word(32'd16385);
        repeat (4) @(negedge clk);
        check("big_flags", {29'b0, uart_done, busy, load_err}, 32'h1);

        // Reset in the middle of a load (including a partial word), then a full re-send.
        do_reset();
        send_word(32'd2);
        send_word(32'hAAAA5555);
        send_byte(8'h77, 1'b1);
        send_byte(8'h66, 1'b1);
        do_reset();
        check("mid_rst_cnt", {17'b0, word_cnt}, 32'h0);
        base = wr_data_q.size();
        send_word(32'd1);
        send_word(32'hCAFEF00D);
        repeat (4) @(negedge clk);
        check("rel_nwr", wr_data_q.size() - base, 1);
        if (wr_data_q.size() - base == 1) begin
            check("rel_data", wr_data_q[base], 32'hCAFEF00D);
            check("rel_addr", wr_addr_q[base], 32'h0);
            check("rel_done_lat", done_rise_cyc, wr_cyc_q[base] + 1);
        end
        check("rel_done", {29'b0, uart_done, busy, load_err}, 32'h4);

`ifdef UART_LOADER_CHECKSUM_EN
        // Correct trailing checksum.
        do_reset();
        send_word(32'd2);
        send_word(32'd1);
        send_word(32'd2);
        send_word(32'd3);
        repeat (4) @(negedge clk);
        check("csum_ok", {29'b0, uart_done, busy, load_err}, 32'h4);
        // Wrong trailing checksum.
        do_reset();
        send_word(32'd2);
        send_word(32'd1);
        send_word(32'd2);
        send_word(32'd4);
        repeat (4) @(negedge clk);
        check("csum_bad", {29'b0, uart_done, busy, load_err}, 32'h1);
`else
        // Without the checksum stage the last payload word completes the load.
        do_reset();
        base = wr_data_q.size();
        send_word(32'd2);
        send_word(32'd1);
        check("two_mid", {29'b0, uart_done, busy, load_err}, 32'h2);
        send_word(32'd2);
        repeat (4) @(negedge clk);
        check("two_done", {29'b0, uart_done, busy, load_err}, 32'h4);
        check("two_nwr", wr_data_q.size() - base, 2);
        if (wr_data_q.size() - base == 2) check("two_a1", wr_addr_q[base + 1], 32'h4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
